uart_fifo_bridge: RTL and testbench
===================================

UART_FIFO_BRIDGE -- requirements
Module: uart_fifo_bridge

Interface
REQ-001 Parameter: DEPTH, default 16, entries per FIFO; power of two, 4..256.
REQ-002 Parameter: BUSY_TIMEOUT, default 3, maximum cycles to wait for uart_is_transmitting to rise after a transmit pulse.
REQ-003 Port: clk  in  1  the only clock; all logic on its rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: uart_rx_byte  in  8  byte from the UART receiver.
REQ-006 Port: uart_received  in  1  one-cycle strobe; uart_rx_byte is valid.
REQ-007 Port: uart_transmit  out  1  one-cycle strobe to the UART transmitter.
REQ-008 Port: uart_tx_byte  out  8  byte for the UART transmitter; held stable from the strobe until the FSM returns to IDLE.
REQ-009 Port: uart_is_transmitting  in  1  UART transmitter busy.
REQ-010 Port: rx_data  out  8  RX FIFO head (first-word fall-through).
REQ-011 Port: rx_valid  out  1  RX FIFO is non-empty.
REQ-012 Port: rx_pop  in  1  consume the head.
REQ-013 Port: tx_data  in  8  byte to queue for transmission.
REQ-014 Port: tx_push  in  1  enqueue tx_data.
REQ-015 Port: tx_full  out  1  TX FIFO is full.
REQ-016 Port: rx_count, tx_count  out  log2(DEPTH)+1  FIFO occupancy.
REQ-017 Port: rx_overflow, tx_overflow  out  1  sticky drop flags.
REQ-018 Port: ovf_clear  in  1  clears both sticky flags.

Function
REQ-019 RX push: uart_received=1 and RX FIFO not full writes uart_rx_byte; rx_valid and rx_data reflect it in the next cycle.
REQ-020 RX full: uart_received=1 with rx_count=DEPTH and no pop drops the byte and sets rx_overflow in the next cycle.
REQ-021 RX pop: rx_pop=1 with rx_valid=1 advances the head; rx_pop with rx_valid=0 is ignored.
REQ-022 RX push and pop in the same cycle: when the FIFO is full, both take effect and the count is unchanged; when empty, only the push takes effect.
REQ-023 TX push: tx_push=1 with tx_full=0 enqueues tx_data; tx_push with tx_full=1 drops the byte and sets tx_overflow.
REQ-024 TX push while full and the TX FSM pops in the same cycle: the push is accepted.
REQ-025 Pointers: wrap modulo DEPTH; count is the registered difference; never exceeds DEPTH and never underflows.
REQ-026 ovf_clear=1 clears both flags next cycle; a simultaneous new overflow wins and the flag stays set.
REQ-027 TX FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-028 IDLE -> LOAD when tx_count>0; the head is registered into uart_tx_byte and popped on this transition.
REQ-029 LOAD: uart_transmit=1 for exactly this cycle; then -> WAIT_BUSY.
REQ-030 WAIT_BUSY: -> WAIT_DONE when uart_is_transmitting=1; after BUSY_TIMEOUT cycles without it, -> IDLE.
REQ-031 WAIT_DONE: -> IDLE when uart_is_transmitting=0.
REQ-032 uart_transmit is never asserted in two consecutive cycles; at most one byte is in flight.
REQ-033 Latency: tx_push in cycle N gives LOAD (strobe) in cycle N+2 when the FSM is IDLE.

Reset
REQ-034 rst=1 on a clock edge: both FIFOs empty (pointers and counts 0), FSM IDLE, uart_transmit=0, uart_tx_byte=0, rx_valid=0, tx_full=0, both overflow flags 0.
REQ-035 Reset mid-frame discards queued bytes; the bridge does not abort a frame already handed to the UART.
REQ-036 rx_data is don't-care while rx_valid=0.

Structure
REQ-037 Package uart_fifo_pkg holds the TX state enum, the DEPTH default and the BUSY_TIMEOUT default.
REQ-038 One sub-module, byte_fifo (8-bit, DEPTH entries, FWFT, count, full/empty), is instantiated twice.

Verification
REQ-039 Reset, then uart_received with 0x41 -> rx_valid=1 and rx_data=0x41 the next cycle; rx_pop -> rx_valid=0.
REQ-040 DEPTH+1 strobes with no pops -> rx_count=16, rx_overflow=1, head still the first byte; ovf_clear -> flag 0.
REQ-041 Full RX FIFO with strobe and rx_pop in the same cycle -> count stays 16, no overflow, new byte at the tail.
REQ-042 Push 0x55 and 0xAA, UART model busy 10 cycles per byte -> two single-cycle strobes in order, second only after busy falls.
REQ-043 UART model never asserts busy -> FSM returns to IDLE after 3 WAIT_BUSY cycles and sends the next byte.
REQ-044 rst asserted during WAIT_DONE with 5 bytes queued -> next cycle tx_count=0, FSM IDLE, uart_transmit=0.

Source files
------------

// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg
// Shared definitions for the UART FIFO bridge: the transmit FSM state
// encoding and the default sizing/timeout parameters.
// No ports (package).

package uart_fifo_pkg;

  localparam int DEFAULT_DEPTH        = 16;
  localparam int DEFAULT_BUSY_TIMEOUT = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo
// Byte-wide synchronous FIFO with first-word fall-through output and a
// registered occupancy count.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en, wr_data    write request and byte; ignored while full unless a
//                     read is accepted in the same cycle
//   rd_en             consume the head; ignored while empty
//   rd_data           current head (meaningless while empty)
//   count             occupancy, 0..DEPTH
//   full, empty       occupancy flags derived from count

module byte_fifo
  import uart_fifo_pkg::*;
#(
  parameter int  DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  // A read in the same cycle frees the slot, so a full FIFO still accepts
  // the write; when full, wr_ptr == rd_ptr and the outgoing head is
  // overwritten only after it has been presented this cycle.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two; the count
  // tracks the difference so it can distinguish full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge
// Buffers bytes between a UART core and a client: received bytes are
// queued in an RX FIFO for the client, client bytes are queued in a TX FIFO
// and handed to the UART transmitter one at a time by a small FSM.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   uart_rx_byte, uart_received      byte + strobe from the UART receiver
//   uart_transmit, uart_tx_byte      strobe + byte to the UART transmitter
//   uart_is_transmitting             UART transmitter busy
//   rx_data, rx_valid, rx_pop        RX FIFO head (FWFT), non-empty, consume
//   tx_data, tx_push, tx_full        TX enqueue interface
//   rx_count, tx_count               FIFO occupancies
//   rx_overflow, tx_overflow         sticky dropped-byte flags
//   ovf_clear                        clears both sticky flags

module uart_fifo_bridge
  import uart_fifo_pkg::*;
#(
  parameter int  DEPTH        = DEFAULT_DEPTH,
  parameter int  BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT,
  localparam int CW           = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    uart_rx_byte,
  input  logic          uart_received,
  output logic          uart_transmit,
  output logic [7:0]    uart_tx_byte,
  input  logic          uart_is_transmitting,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  input  logic          rx_pop,
  input  logic [7:0]    tx_data,
  input  logic          tx_push,
  output logic          tx_full,
  output logic [CW-1:0] rx_count,
  output logic [CW-1:0] tx_count,
  output logic          rx_overflow,
  output logic          tx_overflow,
  input  logic          ovf_clear
);

  localparam int TW = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT);

  tx_state_e     state;
  tx_state_e     next_state;
  logic          rx_empty;
  logic          rx_full;
  logic          tx_empty;
  logic          tx_pop;
  logic [7:0]    tx_head;
  logic [TW-1:0] busy_timer;
  logic          timer_expired;
  logic          rx_drop;
  logic          tx_drop;

  byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (uart_received),
    .wr_data (uart_rx_byte),
    .rd_en   (rx_pop),
    .rd_data (rx_data),
    .count   (rx_count),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_push),
    .wr_data (tx_data),
    .rd_en   (tx_pop),
    .rd_data (tx_head),
    .count   (tx_count),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  assign rx_valid = !rx_empty;

  // A byte is dropped only when its FIFO is full and nothing leaves the
  // FIFO in the same cycle.
  assign rx_drop = uart_received && rx_full && !(rx_pop && rx_valid);
  assign tx_drop = tx_push && tx_full && !tx_pop;

  // Sticky flags: a new drop takes priority over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_overflow <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (rx_drop)        rx_overflow <= 1'b1;
      else if (ovf_clear) rx_overflow <= 1'b0;
      if (tx_drop)        tx_overflow <= 1'b1;
      else if (ovf_clear) tx_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // The head is popped on the IDLE->LOAD transition so the strobe cycle
  // already presents a registered, stable byte.
  always_comb begin
    next_state    = state;
    tx_pop        = 1'b0;
    uart_transmit = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_empty) begin
          next_state = LOAD;
          tx_pop     = 1'b1;
        end
      end
      LOAD: begin
        uart_transmit = 1'b1;
        next_state    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_is_transmitting) next_state = WAIT_DONE;
        else if (timer_expired)   next_state = IDLE;
      end
      WAIT_DONE: begin
        if (!uart_is_transmitting) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Counts WAIT_BUSY cycles; held at zero elsewhere so every visit starts
  // fresh and the FSM gives up after exactly BUSY_TIMEOUT cycles.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT_BUSY) busy_timer <= '0;
    else                           busy_timer <= busy_timer + TW'(1);
  end

  assign timer_expired = (busy_timer == TW'(BUSY_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst)         uart_tx_byte <= 8'h00;
    else if (tx_pop) uart_tx_byte <= tx_head;
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb_uart_fifo_bridge
// Self-checking bench for uart_fifo_bridge: a table of RX-path vectors plus
// hand-written TX sequences against a simple UART busy model.

module tb_uart_fifo_bridge;

  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    uart_rx_byte;
  logic          uart_received;
  logic          uart_transmit;
  logic [7:0]    uart_tx_byte;
  logic          uart_is_transmitting;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_pop;
  logic [7:0]    tx_data;
  logic          tx_push;
  logic          tx_full;
  logic [CW-1:0] rx_count;
  logic [CW-1:0] tx_count;
  logic          rx_overflow;
  logic          tx_overflow;
  logic          ovf_clear;

  int vec_count   = 0;
  int miscompares = 0;

  uart_fifo_bridge #(.DEPTH(DEPTH), .BUSY_TIMEOUT(3)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .uart_rx_byte         (uart_rx_byte),
    .uart_received        (uart_received),
    .uart_transmit        (uart_transmit),
    .uart_tx_byte         (uart_tx_byte),
    .uart_is_transmitting (uart_is_transmitting),
    .rx_data              (rx_data),
    .rx_valid             (rx_valid),
    .rx_pop               (rx_pop),
    .tx_data              (tx_data),
    .tx_push              (tx_push),
    .tx_full              (tx_full),
    .rx_count             (rx_count),
    .tx_count             (tx_count),
    .rx_overflow          (rx_overflow),
    .tx_overflow          (tx_overflow),
    .ovf_clear            (ovf_clear)
  );

  always #5 clk = ~clk;

  // Cycle index: the value seen during a cycle names that cycle.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // UART transmitter model: a strobe starts busy_len busy cycles (0 = never busy).
  int busy_len = 0;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (uart_transmit && busy_len > 0) busy_cnt <= busy_len;
    else if (busy_cnt > 0)             busy_cnt <= busy_cnt - 1;
  end
  assign uart_is_transmitting = (busy_cnt > 0);

  // Strobe log, sampled mid-cycle.
  logic [7:0] strobe_bytes[$];
  int         strobe_cycs[$];
  logic       strobe_busy[$];
  logic       prev_strobe = 1'b0;
  int         consec_err  = 0;
  always @(negedge clk) begin
    if (uart_transmit) begin
      strobe_bytes.push_back(uart_tx_byte);
      strobe_cycs.push_back(cyc);
      strobe_busy.push_back(uart_is_transmitting);
      if (prev_strobe) consec_err <= consec_err + 1;
    end
    prev_strobe <= uart_transmit;
  end

  typedef struct {
    logic       rcv;
    logic [7:0] rx_byte;
    logic       pop;
    logic       clr;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_count;
    logic       exp_ovf;
  } rx_vec_t;

  rx_vec_t vecs[$];

  function automatic void add_vec(int rcv, int b, int pop, int clr,
                                  int ev, int ed, int ec, int eo);
    rx_vec_t v;
    v.rcv       = rcv[0];
    v.rx_byte   = 8'(b);
    v.pop       = pop[0];
    v.clr       = clr[0];
    v.exp_valid = ev[0];
    v.exp_data  = 8'(ed);
    v.exp_count = ec;
    v.exp_ovf   = eo[0];
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    vec_count++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input rx_vec_t v);
    uart_received = v.rcv;
    uart_rx_byte  = v.rx_byte;
    rx_pop        = v.pop;
    ovf_clear     = v.clr;
    tick();
  endtask

  task automatic clear_log();
    strobe_bytes.delete();
    strobe_cycs.delete();
    strobe_busy.delete();
  endtask

  task automatic wait_strobes(input int n, input int budget, input string name);
    int guard = 0;
    while (strobe_bytes.size() < n && guard < budget) begin
      tick();
      guard++;
    end
    checkOutput(name, strobe_bytes.size(), n);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int guard;
    logic [7:0] exp_q[$];

    rst = 1'b1; uart_rx_byte = 8'h00; uart_received = 1'b0; rx_pop = 1'b0;
    tx_data = 8'h00; tx_push = 1'b0; ovf_clear = 1'b0;

    // Reset state
    tick(); tick();
    checkOutput("rst_rx_valid", int'(rx_valid), 0);
    checkOutput("rst_rx_count", int'(rx_count), 0);
    checkOutput("rst_tx_count", int'(tx_count), 0);
    checkOutput("rst_tx_full", int'(tx_full), 0);
    checkOutput("rst_uart_transmit", int'(uart_transmit), 0);
    checkOutput("rst_uart_tx_byte", int'(uart_tx_byte), 0);
    checkOutput("rst_rx_overflow", int'(rx_overflow), 0);
    checkOutput("rst_tx_overflow", int'(tx_overflow), 0);
    rst = 1'b0;

    // RX path table: rcv, byte, pop, clr | valid, data, count, ovf
    add_vec(1, 'h41, 0, 0, 1, 'h41, 1, 0);
    add_vec(0, 0,    1, 0, 0, 0,    0, 0);
    add_vec(0, 0,    1, 0, 0, 0,    0, 0);
    for (int k = 0; k < 16; k++) add_vec(1, 'h10 + k, 0, 0, 1, 'h10, k + 1, 0);
    add_vec(1, 'h99, 0, 0, 1, 'h10, 16, 1);
    add_vec(0, 0,    0, 1, 1, 'h10, 16, 0);
    add_vec(1, 'h77, 1, 0, 1, 'h11, 16, 0);
    for (int k = 1; k <= 14; k++) add_vec(0, 0, 1, 0, 1, 'h11 + k, 16 - k, 0);
    add_vec(0, 0,    1, 0, 1, 'h77, 1, 0);
    add_vec(0, 0,    1, 0, 0, 0,    0, 0);
    add_vec(1, 'h5A, 1, 0, 1, 'h5A, 1, 0);
    add_vec(0, 0,    1, 0, 0, 0,    0, 0);
    for (int k = 0; k < 16; k++) add_vec(1, 'h60 + k, 0, 0, 1, 'h60, k + 1, 0);
    add_vec(1, 'hEE, 0, 1, 1, 'h60, 16, 1);
    add_vec(0, 0,    0, 1, 1, 'h60, 16, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("rx_valid[%0d]", i), int'(rx_valid), int'(vecs[i].exp_valid));
      checkOutput($sformatf("rx_count[%0d]", i), int'(rx_count), vecs[i].exp_count);
      checkOutput($sformatf("rx_overflow[%0d]", i), int'(rx_overflow), int'(vecs[i].exp_ovf));
      if (vecs[i].exp_valid)
        checkOutput($sformatf("rx_data[%0d]", i), int'(rx_data), int'(vecs[i].exp_data));
    end
    uart_received = 1'b0; rx_pop = 1'b0; ovf_clear = 1'b0;

    // Two bytes, UART busy 10 cycles each
    busy_len = 10;
    clear_log();
    base = cyc;
    tx_data = 8'h55; tx_push = 1'b1; tick();
    tx_data = 8'hAA; tick();
    tx_push = 1'b0;
    repeat (6) tick();
    checkOutput("tx_byte_hold", int'(uart_tx_byte), 'h55);
    wait_strobes(2, 60, "busy_strobe_count");
    if (strobe_bytes.size() >= 2) begin
      checkOutput("busy_byte0", int'(strobe_bytes[0]), 'h55);
      checkOutput("busy_cyc0", strobe_cycs[0] - base, 2);
      checkOutput("busy_byte1", int'(strobe_bytes[1]), 'hAA);
      checkOutput("busy_cyc1", strobe_cycs[1] - base, 15);
      checkOutput("busy_low_at_strobe1", int'(strobe_busy[1]), 0);
    end
    repeat (20) tick();

    // UART never busy: timeout after 3 WAIT_BUSY cycles
    busy_len = 0;
    clear_log();
    base = cyc;
    tx_data = 8'h31; tx_push = 1'b1; tick();
    tx_data = 8'h32; tick();
    tx_push = 1'b0;
    wait_strobes(2, 40, "timeout_strobe_count");
    if (strobe_bytes.size() >= 2) begin
      checkOutput("timeout_byte0", int'(strobe_bytes[0]), 'h31);
      checkOutput("timeout_cyc0", strobe_cycs[0] - base, 2);
      checkOutput("timeout_byte1", int'(strobe_bytes[1]), 'h32);
      checkOutput("timeout_cyc1", strobe_cycs[1] - base, 7);
    end
    repeat (10) tick();

    // TX fill, overflow, clear, push-while-full with simultaneous pop
    busy_len = 40;
    clear_log();
    for (int k = 0; k < 18; k++) begin
      tx_data = 8'(8'h80 + k);
      tx_push = 1'b1;
      tick();
      if (k == 16) begin
        checkOutput("tx_full_at_16", int'(tx_full), 1);
        checkOutput("tx_count_at_16", int'(tx_count), 16);
        checkOutput("tx_ovf_before_drop", int'(tx_overflow), 0);
      end
    end
    tx_push = 1'b0;
    checkOutput("tx_count_after_drop", int'(tx_count), 16);
    checkOutput("tx_ovf_after_drop", int'(tx_overflow), 1);
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    checkOutput("tx_ovf_cleared", int'(tx_overflow), 0);
    guard = 0;
    while (uart_is_transmitting && guard < 100) begin
      tick();
      guard++;
    end
    checkOutput("busy_fell", int'(uart_is_transmitting), 0);
    tick();
    busy_len = 0;
    tx_data = 8'hC7; tx_push = 1'b1; tick(); tx_push = 1'b0;
    checkOutput("push_pop_full_count", int'(tx_count), 16);
    checkOutput("push_pop_full_ovf", int'(tx_overflow), 0);
    checkOutput("push_pop_full_flag", int'(tx_full), 1);
    exp_q.delete();
    for (int k = 0; k <= 16; k++) exp_q.push_back(8'(8'h80 + k));
    exp_q.push_back(8'hC7);
    wait_strobes(18, 200, "drain_strobe_count");
    if (strobe_bytes.size() >= 18)
      foreach (exp_q[i]) checkOutput($sformatf("drain_byte[%0d]", i), int'(strobe_bytes[i]), int'(exp_q[i]));
    repeat (10) tick();

    // Reset during WAIT_DONE with 5 bytes queued
    busy_len = 30;
    clear_log();
    for (int k = 0; k < 6; k++) begin
      tx_data = 8'(8'hD0 + k);
      tx_push = 1'b1;
      tick();
    end
    tx_push = 1'b0;
    checkOutput("pre_rst_tx_count", int'(tx_count), 5);
    checkOutput("pre_rst_strobes", strobe_bytes.size(), 1);
    checkOutput("pre_rst_busy", int'(uart_is_transmitting), 1);
    rst = 1'b1; tick();
    checkOutput("mid_rst_tx_count", int'(tx_count), 0);
    checkOutput("mid_rst_transmit", int'(uart_transmit), 0);
    checkOutput("mid_rst_tx_byte", int'(uart_tx_byte), 0);
    checkOutput("mid_rst_rx_count", int'(rx_count), 0);
    checkOutput("mid_rst_rx_valid", int'(rx_valid), 0);
    checkOutput("mid_rst_tx_full", int'(tx_full), 0);
    rst = 1'b0;
    busy_len = 0;
    base = cyc;
    tx_data = 8'hE5; tx_push = 1'b1; tick(); tx_push = 1'b0;
    wait_strobes(2, 40, "post_rst_strobe_count");
    if (strobe_bytes.size() >= 2) begin
      checkOutput("post_rst_byte", int'(strobe_bytes[1]), 'hE5);
      checkOutput("post_rst_cyc", strobe_cycs[1] - base, 2);
    end
    repeat (5) tick();

    checkOutput("no_back_to_back", consec_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
